axi_ram_slave: RTL and testbench
================================

Name: axi_ram_slave

Overview:
- AXI3-subset slave (responder) with 32-bit data that serves one transaction at a time from an internal word-addressed RAM.
- It is the far end of the CPU's SRAM-to-AXI bridge: the simulation and FPGA memory model that the CPU top's AXI master talks to.
- Supports FIXED and INCR bursts of 1–16 beats, byte-strobed writes, and error responses for bad addresses or bursts.

Parameters:
- ADDR_W, 12, word-address bits; RAM depth = 2^ADDR_W words (16 KiB default).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- arid/awid  in  4  request IDs.
- araddr/awaddr  in  32  byte addresses.
- arlen/awlen  in  8  beats-1; values >15 get SLVERR.
- arsize/awsize  in  3  only 3'd2 is legal; other values get SLVERR.
- arburst/awburst  in  2  00 FIXED, 01 INCR; 10 or 11 get SLVERR.
- arlock, arcache, arprot, awlock, awcache, awprot  in  2/4/3 each  ignored.
- arvalid/awvalid  in  1  request valid.
- arready/awready  out  1  request accept.
- rid  out  4  echoes the latched arid.
- rdata  out  32  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  final read beat.
- rvalid  out  1  read beat valid.
- rready  in  1  master accepts read beat.
- wid  in  4  ignored (AXI3 interleaving not supported).
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1  write beat valid.
- wready  out  1  write beat accept.
- bid  out  4  echoes the latched awid.
- bresp  out  2  00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts response.

Behaviour:
- Reset: state=IDLE. arready, awready, wready, rvalid, rlast, bvalid all 0; rdata, rid, rresp, bid, bresp all 0. Reset applies mid-burst as well: the transaction is abandoned and no response is issued.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - awready = !areset && awvalid.
  - arready = !areset && arvalid && !awvalid, so a write wins when both requests are valid in the same cycle.
  - On handshake, latch id, addr, len, burst and the error flag; clear the beat counter. Go to WR_DATA (write) or RD_REQ (read).
- In-range test, applied per beat: (addr-BASE)>>2 < 2^ADDR_W and addr[1:0]==0.
- Error flag is set if any of: arsize/awsize ≠ 2, burst is 10 or 11, or len > 15.
- RD_REQ: drive the RAM read at the current word index; go to RD_DATA the next cycle.
- RD_DATA:
  - rvalid=1. rdata = RAM output, or 0 if the beat is out of range or the error flag is set. rresp = SLVERR in those cases, else OKAY. rlast = (cnt==len).
  - Hold all outputs stable while rready=0.
  - On rready: if last, go to IDLE; else cnt+1, addr advances by 4 (INCR) or stays (FIXED), go to RD_REQ.
  - Throughput is one beat per 2 cycles; first rvalid appears 2 cycles after the ar handshake.
- WR_DATA:
  - wready=1. On wvalid, write the RAM with wstrb only if the beat is in range and the error flag is clear; out-of-range beats set a sticky error.
  - The beat is final when wlast=1 or cnt==len. If wlast ≠ (cnt==len), set sticky SLVERR and end the burst on that beat.
  - On the final beat go to WR_RESP; otherwise cnt+1 and advance addr as for reads.
- WR_RESP: bvalid=1, bid=latched awid, bresp = SLVERR if any error is sticky, else OKAY. Hold until bready, then go to IDLE.
- Only one outstanding transaction. Write address is never accepted before the previous write's response is consumed.
- Address arithmetic is 32-bit wrapping. No 4 KiB-boundary check.
- The RAM is not initialised; a read-after-write to the same word returns the new data.

Decomposition:
- Package axi_pkg holds: BURST_FIXED/INCR, RESP_OKAY/SLVERR, SIZE_WORD=3'd2, the FSM state enum, and ID_W=4.
- One sub-module, sp_ram_be: single-port synchronous RAM with 1-cycle read latency, 4-bit byte write enable and parameter ADDR_W.

Test Plan:
- Read of 1 word at 0x10 after preloading 0xDEADBEEF → rvalid 2 cycles after the handshake; rdata=0xDEADBEEF, rresp=00, rlast=1, rid matches arid=4'h3.
- INCR write, awlen=3, at 0x100, data 1..4 with wstrb=F, then INCR read of the same range → bresp=00, bid=awid; read returns 1,2,3,4 with rlast only on beat 4.
- Write 0xAABBCCDD with wstrb=4'b0101 over 0xFFFFFFFF → readback 0xFFBBFFDD. Hold rready=0 for 5 cycles during a read → rdata, rresp, rlast unchanged.
- arvalid and awvalid asserted in the same cycle → awready=1, arready=0. The read is accepted only after bvalid/bready completes.
- Read at BASE+0x4000 (out of range), arburst=2'b10, and a write with wlast asserted on beat 2 of awlen=3 → each gets SLVERR with rdata=0; RAM contents unchanged by the errored beats.
- areset pulsed during beat 2 of a 4-beat read → the next cycle shows rvalid=0 and state IDLE; a new read then completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3-subset constants, FSM state encoding and request record for the RAM slave.
package axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(15);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_RESP
    } state_e;

    // Latched address-phase payload of the transaction in flight.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        logic [1:0]       burst;
        logic             err;
    } req_t;

    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [LEN_W-1:0] len);
        return (size != SIZE_WORD) ||
               ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
               (len > MAX_LEN);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, one-cycle read latency, per-byte write enables.
module sp_ram_be
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [STRB_W-1:0] we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are intentionally not reset; the output register holds between reads.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3-subset slave serving one FIXED/INCR burst at a time from an internal word RAM.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    state_e            state_q;
    req_t              req_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              werr_q;

    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              beat_ok;
    logic              rd_ok;
    logic              last_beat;
    logic              aw_err;
    logic              ar_err;
    logic              ram_re;
    logic [STRB_W-1:0] ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_ok;

    // Per-beat address decode against the RAM window.
    assign offset    = req_q.addr - BASE;
    assign word_idx  = offset[ADDR_W+1:2];
    assign beat_ok   = (offset[31:ADDR_W+2] == '0) && (req_q.addr[1:0] == 2'b00);
    assign rd_ok     = beat_ok && !req_q.err;
    assign last_beat = (cnt_q == req_q.len);

    assign aw_err = req_err(awsize, awburst, awlen);
    assign ar_err = req_err(arsize, arburst, arlen);

    assign unused_ok = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid, offset[1:0]};

    // Write wins a same-cycle tie between address channels.
    assign awready = (state_q == ST_IDLE) && !areset && awvalid;
    assign arready = (state_q == ST_IDLE) && !areset && arvalid && !awvalid;
    assign wready  = (state_q == ST_WR_DATA);
    assign rvalid  = (state_q == ST_RD_DATA);
    assign bvalid  = (state_q == ST_WR_RESP);

    assign rid   = req_q.id;
    assign bid   = req_q.id;
    assign rdata = (rvalid && rd_ok) ? ram_rdata : '0;
    assign rresp = (rvalid && !rd_ok) ? RESP_SLVERR : RESP_OKAY;
    assign rlast = rvalid && last_beat;
    assign bresp = (bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign ram_re = (state_q == ST_RD_REQ);
    assign ram_we = (wready && wvalid && rd_ok) ? wstrb : '0;

    sp_ram_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (aclk),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .addr_i  (word_idx),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    // Transaction FSM; a reset at any point abandons the burst without a response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (awvalid) begin
                        req_q   <= '{id: awid, addr: awaddr, len: awlen, burst: awburst, err: aw_err};
                        cnt_q   <= '0;
                        werr_q  <= aw_err;
                        state_q <= ST_WR_DATA;
                    end else if (arvalid) begin
                        req_q   <= '{id: arid, addr: araddr, len: arlen, burst: arburst, err: ar_err};
                        cnt_q   <= '0;
                        state_q <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rready) begin
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q      <= cnt_q + LEN_W'(1);
                            req_q.addr <= next_addr(req_q.addr, req_q.burst);
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (wvalid) begin
                        if (!beat_ok || (wlast != last_beat)) begin
                            werr_q <= 1'b1;
                        end
                        if (wlast || last_beat) begin
                            state_q <= ST_WR_RESP;
                        end else begin
                            cnt_q      <= cnt_q + LEN_W'(1);
                            req_q.addr <= next_addr(req_q.addr, req_q.burst);
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: vector table plus scoreboarded corner sequences.
module tb_axi_ram_slave;
    import axi_pkg::*;

    logic        aclk;
    logic        areset;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic        rlast, rvalid, rready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] data;
        logic [31:0] step;
        logic [3:0]  strb;
        int          wlast_at;
        int          bad_from;
        logic [1:0]  resp;
    } vec_t;

    rbeat_t rd_q[$];
    bexp_t  wr_q[$];
    vec_t   vt[25];

    axi_ram_slave #(.ADDR_W(12), .BASE(32'h0000_0000)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT handshake within 50 cycles, expected one", name);
    endtask

    // Every task starts and ends at a falling edge.
    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        #1;
        while (!awready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!awready) timeout_fail("aw_handshake");
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        #1;
        while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!arready) timeout_fail("ar_handshake");
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [7:0] len, input logic [31:0] data, input logic [31:0] step,
                           input logic [3:0] strb, input int wlast_at);
        int nb = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
        for (int k = 0; k < nb; k++) begin
            int n = 0;
            wvalid = 1'b1; wdata = data + 32'(k) * step; wstrb = strb; wlast = (k == wlast_at);
            #1;
            while (!wready && n < 50) begin @(negedge aclk); #1; n++; end
            if (!wready) timeout_fail("w_handshake");
            @(posedge aclk);
            @(negedge aclk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_phase();
        int n = 0;
        bexp_t e;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!bvalid) begin
            timeout_fail("b_wait");
        end else if (wr_q.size() == 0) begin
            timeout_fail("b_unexpected");
        end else begin
            e = wr_q.pop_front();
            chk("bid", 32'(bid), 32'(e.id));
            chk("bresp", 32'(bresp), 32'(e.resp));
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Each beat must appear exactly two cycles after the previous handshake.
    task automatic r_beats(input int nbeats);
        rbeat_t e;
        for (int k = 0; k < nbeats; k++) begin
            int lat = 1;
            while (!rvalid && lat < 50) begin @(negedge aclk); lat++; end
            if (!rvalid || rd_q.size() == 0) begin
                timeout_fail("r_wait");
                return;
            end
            e = rd_q.pop_front();
            chk("r_latency", 32'(lat), 32'd2);
            chk("rdata", rdata, e.data);
            chk("rresp", 32'(rresp), 32'(e.resp));
            chk("rlast", 32'(rlast), 32'(e.last));
            chk("rid", 32'(rid), 32'(e.id));
            @(posedge aclk);
            @(negedge aclk);
        end
    endtask

    task automatic do_write(input vec_t v);
        wr_q.push_back('{v.id, v.resp});
        aw_phase(v.id, v.addr, v.len, v.burst, v.size);
        w_beats(v.len, v.data, v.step, v.strb, v.wlast_at);
        b_phase();
    endtask

    task automatic do_read(input vec_t v);
        for (int k = 0; k <= int'(v.len); k++) begin
            bit bad = (k >= v.bad_from);
            rd_q.push_back('{v.id, bad ? 32'h0 : v.data + 32'(k) * v.step,
                             bad ? RESP_SLVERR : RESP_OKAY, k == int'(v.len)});
        end
        ar_phase(v.id, v.addr, v.len, v.burst, v.size);
        r_beats(int'(v.len) + 1);
    endtask

    initial begin
        //        wr    id     addr           len    burst  size  data           step    strb  wl  bad  resp
        vt[0]  = '{1'b1, 4'h3, 32'h0000_0010, 8'd0,  2'b01, 3'd2, 32'hDEADBEEF, 32'd0, 4'hF, 0,  99, 2'b00};
        vt[1]  = '{1'b0, 4'h3, 32'h0000_0010, 8'd0,  2'b01, 3'd2, 32'hDEADBEEF, 32'd0, 4'hF, 0,  99, 2'b00};
        vt[2]  = '{1'b1, 4'h5, 32'h0000_0100, 8'd3,  2'b01, 3'd2, 32'h1,        32'd1, 4'hF, 3,  99, 2'b00};
        vt[3]  = '{1'b0, 4'h6, 32'h0000_0100, 8'd3,  2'b01, 3'd2, 32'h1,        32'd1, 4'hF, 0,  99, 2'b00};
        vt[4]  = '{1'b1, 4'h1, 32'h0000_0020, 8'd0,  2'b01, 3'd2, 32'hFFFFFFFF, 32'd0, 4'hF, 0,  99, 2'b00};
        vt[5]  = '{1'b1, 4'h2, 32'h0000_0020, 8'd0,  2'b01, 3'd2, 32'hAABBCCDD, 32'd0, 4'h5, 0,  99, 2'b00};
        vt[6]  = '{1'b0, 4'h2, 32'h0000_0020, 8'd0,  2'b01, 3'd2, 32'hFFBBFFDD, 32'd0, 4'hF, 0,  99, 2'b00};
        vt[7]  = '{1'b0, 4'h7, 32'h0000_4000, 8'd0,  2'b01, 3'd2, 32'h0,        32'd0, 4'hF, 0,  0,  2'b00};
        vt[8]  = '{1'b0, 4'h8, 32'h0000_0010, 8'd0,  2'b10, 3'd2, 32'h0,        32'd0, 4'hF, 0,  0,  2'b00};
        vt[9]  = '{1'b0, 4'h9, 32'h0000_0010, 8'd0,  2'b01, 3'd1, 32'h0,        32'd0, 4'hF, 0,  0,  2'b00};
        vt[10] = '{1'b1, 4'h9, 32'h0000_0010, 8'd0,  2'b11, 3'd2, 32'h12345678, 32'd0, 4'hF, 0,  99, 2'b10};
        vt[11] = '{1'b0, 4'h4, 32'h0000_0010, 8'd16, 2'b01, 3'd2, 32'h0,        32'd0, 4'hF, 0,  0,  2'b00};
        vt[12] = '{1'b1, 4'hA, 32'h0000_0200, 8'd3,  2'b01, 3'd2, 32'hA0,       32'd1, 4'hF, 3,  99, 2'b00};
        vt[13] = '{1'b1, 4'hB, 32'h0000_0200, 8'd3,  2'b01, 3'd2, 32'hB0,       32'd1, 4'hF, 1,  99, 2'b10};
        vt[14] = '{1'b0, 4'hB, 32'h0000_0208, 8'd1,  2'b01, 3'd2, 32'hA2,       32'd1, 4'hF, 0,  99, 2'b00};
        vt[15] = '{1'b0, 4'hB, 32'h0000_0200, 8'd0,  2'b01, 3'd2, 32'hB0,       32'd0, 4'hF, 0,  99, 2'b00};
        vt[16] = '{1'b1, 4'hC, 32'h0000_0030, 8'd1,  2'b00, 3'd2, 32'h50,       32'd1, 4'hF, 1,  99, 2'b00};
        vt[17] = '{1'b0, 4'hC, 32'h0000_0030, 8'd1,  2'b00, 3'd2, 32'h51,       32'd0, 4'hF, 0,  99, 2'b00};
        vt[18] = '{1'b1, 4'h0, 32'h0000_0000, 8'd0,  2'b01, 3'd2, 32'h11,       32'd0, 4'hF, 0,  99, 2'b00};
        vt[19] = '{1'b1, 4'hD, 32'h0000_3FFC, 8'd1,  2'b01, 3'd2, 32'h77,       32'd1, 4'hF, 1,  99, 2'b10};
        vt[20] = '{1'b0, 4'hD, 32'h0000_3FFC, 8'd1,  2'b01, 3'd2, 32'h77,       32'd0, 4'hF, 0,  1,  2'b00};
        vt[21] = '{1'b0, 4'h0, 32'h0000_0000, 8'd0,  2'b01, 3'd2, 32'h11,       32'd0, 4'hF, 0,  99, 2'b00};
        vt[22] = '{1'b1, 4'hE, 32'h0000_0050, 8'd0,  2'b01, 3'd2, 32'h66,       32'd0, 4'hF, 5,  99, 2'b10};
        vt[23] = '{1'b0, 4'h1, 32'h0000_0102, 8'd0,  2'b01, 3'd2, 32'h0,        32'd0, 4'hF, 0,  0,  2'b00};
        vt[24] = '{1'b0, 4'h2, 32'h0000_0010, 8'd0,  2'b01, 3'd2, 32'hDEADBEEF, 32'd0, 4'hF, 0,  99, 2'b00};

        // Reset with both requests pending: nothing may be accepted.
        areset = 1'b1; rready = 1'b1; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_rid",     32'(rid),     32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_bid",     32'(bid),     32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        arvalid = 1'b0; awvalid = 1'b0; areset = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 25; i++) begin
            if (vt[i].wr) do_write(vt[i]);
            else          do_read(vt[i]);
        end

        // rready held low: the beat must stay frozen.
        rready = 1'b0;
        ar_phase(4'h6, 32'h20, 8'd0, BURST_INCR, SIZE_WORD);
        @(negedge aclk);
        for (int c = 0; c < 5; c++) begin
            chk("hold_rvalid", 32'(rvalid), 32'd1);
            chk("hold_rdata",  rdata,       32'hFFBBFFDD);
            chk("hold_rresp",  32'(rresp),  32'(RESP_OKAY));
            chk("hold_rlast",  32'(rlast),  32'd1);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("hold_release_rvalid", 32'(rvalid), 32'd0);

        // Simultaneous requests: write first, read only after the write response.
        awid = 4'hA; awaddr = 32'h40; awlen = 8'd0; awburst = BURST_INCR; awsize = SIZE_WORD;
        arid = 4'hB; araddr = 32'h40; arlen = 8'd0; arburst = BURST_INCR; arsize = SIZE_WORD;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("tie_awready", 32'(awready), 32'd1);
        chk("tie_arready", 32'(arready), 32'd0);
        wr_q.push_back('{4'hA, RESP_OKAY});
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        #1;
        chk("tie_arready_wdata", 32'(arready), 32'd0);
        w_beats(8'd0, 32'hCAFEF00D, 32'd0, 4'hF, 0);
        chk("tie_arready_wresp", 32'(arready), 32'd0);
        b_phase();
        chk("tie_arready_after_b", 32'(arready), 32'd1);
        rd_q.push_back('{4'hB, 32'hCAFEF00D, RESP_OKAY, 1'b1});
        ar_phase(4'hB, 32'h40, 8'd0, BURST_INCR, SIZE_WORD);
        r_beats(1);

        // Reset during beat 2 of a 4-beat read, then a clean retry.
        for (int k = 0; k < 4; k++) rd_q.push_back('{4'hC, 32'(k + 1), RESP_OKAY, k == 3});
        ar_phase(4'hC, 32'h100, 8'd3, BURST_INCR, SIZE_WORD);
        r_beats(1);
        rready = 1'b0;
        @(negedge aclk);
        chk("mid_rvalid_beat2", 32'(rvalid), 32'd1);
        chk("mid_rdata_beat2",  rdata,       32'd2);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_state",  32'(dut.state_q), 32'(ST_IDLE));
        areset = 1'b0; rready = 1'b1;
        rd_q.delete();
        do_read('{1'b0, 4'hD, 32'h100, 8'd3, BURST_INCR, SIZE_WORD, 32'h1, 32'd1, 4'hF, 0, 99, RESP_OKAY});

        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500us, expected completion");
        $fatal(1);
    end

endmodule
